// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and bit-timing helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_e;
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
endpackage

// File: rtl/uart_sync_2ff.sv
// uart_sync_2ff: two-flop synchroniser for an asynchronous idle-high input
module uart_sync_2ff (
  input  logic i_Clock,
  input  logic i_Rst_L,
  input  logic i_D,
  output logic o_Q
);
  logic meta_q, sync_q;
  always_ff @(posedge i_Clock or negedge i_Rst_L)
    if (!i_Rst_L) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= i_D;
      sync_q <= meta_q;
    end
  assign o_Q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, valid strobe and framing-error strobe
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 25000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_RX_Frame_Err
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW = $clog2(CPB) + 1;
  localparam logic [CW-1:0] HALF = CW'((CPB - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  logic r_rx;
  state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d, byte_q, byte_d;
  logic dv_q, dv_d, ferr_q, ferr_d, active_q, active_d;
  uart_sync_2ff u_sync (
    .i_Clock(i_Clock),
    .i_Rst_L(i_Rst_L),
    .i_D    (i_RX_Serial),
    .o_Q    (r_rx)
  );
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d = idx_q;
    shift_d = shift_q;
    byte_d = byte_q;
    dv_d = 1'b0;
    ferr_d = 1'b0;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        count_d = '0;
        state_d = r_rx ? IDLE : START;
        active_d = !r_rx;
      end
      START: begin
        count_d = (count_q == HALF) ? '0 : count_q + 1'b1;
        idx_d = '0;
        state_d = (count_q != HALF) ? START : r_rx ? IDLE : DATA;
        active_d = !(count_q == HALF && r_rx);
      end
      DATA:
        if (count_q == LAST) begin
          count_d = '0;
          shift_d[idx_q] = r_rx;
          idx_d = idx_q + 3'd1;
          state_d = (idx_q == 3'd7) ? STOP : DATA;
        end else
          count_d = count_q + 1'b1;
      STOP:
        if (count_q == LAST) begin
          count_d = '0;
          active_d = 1'b0;
          dv_d = r_rx;
          ferr_d = !r_rx;
          byte_d = r_rx ? shift_q : byte_q;
          state_d = r_rx ? IDLE : WAIT_IDLE;
        end else
          count_d = count_q + 1'b1;
      WAIT_IDLE: state_d = r_rx ? IDLE : WAIT_IDLE;
      default: begin
        state_d = IDLE;
        count_d = '0;
        active_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge i_Clock or negedge i_Rst_L)
    if (!i_Rst_L) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      byte_q <= '0;
      dv_q <= 1'b0;
      ferr_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      byte_q <= byte_d;
      dv_q <= dv_d;
      ferr_q <= ferr_d;
      active_q <= active_d;
    end
  assign o_RX_DV = dv_q;
  assign o_RX_Byte = byte_q;
  assign o_RX_Active = active_q;
  assign o_RX_Frame_Err = ferr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 115200, 9600 and 921600 baud
module tb_uart_rx;
  typedef struct {
    int inst;
    bit fe;
    logic [7:0] b;
    longint t0;
  } exp_t;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic [2:0] rx = 3'b111;
  logic [2:0] dv, fe, act;
  logic [7:0] by [3];
  exp_t sb[$];
  exp_t e_m;
  logic [7:0] last [3] = '{8'h00, 8'h00, 8'h00};
  int checks = 0;
  int fails = 0;
  int act_len = 0;
  int last_len = 0;
  bit act_seen = 1'b0;
  longint lat;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int BAUD = (g == 0) ? 115200 : (g == 1) ? 9600 : 921600;
    uart_rx #(.CLK_FREQ(25000000), .BAUD_RATE(BAUD)) u_dut (
      .i_Clock       (clk),
      .i_Rst_L       (rst_l),
      .i_RX_Serial   (rx[g]),
      .o_RX_DV       (dv[g]),
      .o_RX_Byte     (by[g]),
      .o_RX_Active   (act[g]),
      .o_RX_Frame_Err(fe[g])
    );
  end
  function automatic int cpb_of(input int g);
    return (g == 0) ? 217 : (g == 1) ? 2604 : 27;
  endfunction
  function automatic int half_of(input int g);
    return (g == 0) ? 108 : (g == 1) ? 1301 : 13;
  endfunction
  task automatic chk(input string nm, input longint got, input longint want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask
  task automatic chk_rng(input string nm, input longint got, input longint lo, input longint hi);
    checks++;
    if (got < lo || got > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, got, lo, hi);
    end
  endtask
  task automatic send(input int g, input logic [7:0] b, input bit stop, input int skew);
    int bn;
    bn = cpb_of(g) * 10 * (100 + skew) / 100;
    rx[g] = 1'b0;
    sb.push_back('{g, !stop, stop ? b : last[g], $time});
    if (stop) last[g] = b;
    #(bn);
    for (int i = 0; i < 8; i++) begin
      rx[g] = b[i];
      #(bn);
    end
    rx[g] = stop;
    #(bn);
  endtask
  always @(negedge clk) begin
    if (act[0]) begin
      act_seen = 1'b1;
      act_len++;
    end else if (act_len != 0) begin
      last_len = act_len;
      act_len = 0;
    end
    for (int g = 0; g < 3; g++)
      if (dv[g] || fe[g]) begin
        chk($sformatf("dv_fe_exclusive_%0d", g), dv[g] & fe[g], 0);
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_strobe inst %0d: got dv=%b fe=%b expected none", g, dv[g], fe[g]);
        end else begin
          e_m = sb.pop_front();
          lat = ($time - e_m.t0) / 10;
          chk("strobe_inst", g, e_m.inst);
          chk($sformatf("strobe_kind_fe_%0d", g), fe[g], e_m.fe);
          chk($sformatf("rx_byte_%0d", g), by[g], e_m.b);
          chk_rng($sformatf("latency_%0d", g), lat, half_of(g) + 9 * cpb_of(g) + 1, half_of(g) + 9 * cpb_of(g) + 7);
        end
      end
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_dv", dv, 0);
    chk("reset_fe", fe, 0);
    chk("reset_act", act, 0);
    chk("reset_byte", by[0], 0);
    rst_l = 1'b1;
    repeat (2000) @(posedge clk);
    @(negedge clk);
    chk("idle_act_seen", act_seen, 0);
    chk("idle_byte", by[0], 0);
    @(posedge clk) #1;
    send(0, 8'hA5, 1'b1, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("a5_held", by[0], 8'hA5);
    @(posedge clk) #1;
    send(0, 8'h00, 1'b1, 0);
    send(0, 8'hFF, 1'b1, 0);
    send(0, 8'h3C, 1'b1, 0);
    repeat (20) @(posedge clk);
    @(posedge clk) #1;
    rx[0] = 1'b0;
    repeat (50) @(posedge clk);
    rx[0] = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    chk_rng("glitch_active_len", last_len, 1, 110);
    chk("glitch_act_low", act[0], 0);
    chk("glitch_byte_kept", by[0], 8'h3C);
    @(posedge clk) #1;
    send(0, 8'h55, 1'b0, 0);
    repeat (500) @(posedge clk);
    @(negedge clk);
    chk("break_no_retrigger", act[0], 0);
    chk("ferr_byte_kept", by[0], 8'h3C);
    rx[0] = 1'b1;
    #(2 * 2170);
    send(0, 8'h12, 1'b1, 0);
    repeat (20) @(posedge clk);
    @(posedge clk) #1;
    rx[0] = 1'b0;
    #(2170 * 5 + 1085);
    chk("mid_frame_active", act[0], 1);
    #3;
    rst_l = 1'b0;
    rx[0] = 1'b1;
    #1;
    chk("async_reset_act", act[0], 0);
    chk("async_reset_byte", by[0], 0);
    last[0] = 8'h00;
    repeat (5) @(posedge clk);
    @(negedge clk) rst_l = 1'b1;
    repeat (3000) @(posedge clk);
    @(negedge clk);
    chk("post_reset_quiet", act[0], 0);
    @(posedge clk) #1;
    send(0, 8'h7E, 1'b1, 0);
    repeat (20) @(posedge clk);
    @(posedge clk) #1;
    send(1, 8'hA5, 1'b1, 2);
    @(posedge clk) #1;
    send(2, 8'hA5, 1'b1, 2);
    send(2, 8'h00, 1'b1, -2);
    send(2, 8'hFF, 1'b1, -2);
    send(2, 8'h3C, 1'b1, -2);
    send(2, 8'h00, 1'b1, 2);
    send(2, 8'hFF, 1'b1, 2);
    send(2, 8'h3C, 1'b1, 2);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("byte_9600", by[1], 8'hA5);
    chk("byte_921600", by[2], 8'h3C);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
